timelock_sequencer: RTL and testbench

- Byte-command sequencer for the timelock Montgomery core (the `test_timelock_*` family).
- Loads the 2W-bit operand nibble-serially, sets a round count, and chains the core for that many rounds, feeding each result back as the next input.
- Streams the result out byte-serially.
- Sits between the UART rx/tx byte interfaces and the core; single clock domain.

---
 rtl/timelock_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_timelock_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/timelock_sequencer.sv
// timelock_sequencer: byte-command sequencer that loads, chains and reads back the timelock Montgomery core.
// Optional TIMELOCK_SEQ_CYCLE_COUNT_EN adds a saturating compute-cycle counter readable with opcode 4.
module timelock_sequencer #(
    parameter int W  = 184,
    parameter int RW = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [7:0]   cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [7:0]   rsp_data,
    output logic         core_ld,
    output logic [W-1:0] core_xs,
    output logic [W-1:0] core_xc,
    input  logic         core_dn,
    input  logic [W-1:0] core_ys,
    input  logic [W-1:0] core_yc,
    output logic         busy
);
    localparam int NB = 2 * W / 8;
    localparam int IW = (NB > 4) ? $clog2(NB) : 2;

    typedef enum logic [2:0] {IDLE, RESP, CORE_LD, CORE_WAIT, READ_OUT} state_t;

    state_t         r_state;
    logic [2*W-1:0] r_x;
    logic [RW-1:0]  r_rounds;
    logic [IW-1:0]  r_idx;
    logic [7:0]     r_rsp_data;
    logic           r_first, r_cmd_ready, r_rsp_valid, r_core_ld, r_busy;

    logic [3:0]     w_op, w_arg;
    logic [IW-1:0]  w_idx_nx;
    logic           w_last;
    logic [7:0]     w_byte_nx;

    assign w_op     = cmd_data[3:0];
    assign w_arg    = cmd_data[7:4];
    assign w_idx_nx = r_idx + 1'b1;

`ifdef TIMELOCK_SEQ_CYCLE_COUNT_EN
    logic [31:0] r_cyc;
    logic        r_rd_cyc;

    // READ_OUT serves either the operand or the 4-byte cycle counter
    assign w_last    = r_rd_cyc ? (r_idx == IW'(3)) : (r_idx == IW'(NB - 1));
    assign w_byte_nx = r_rd_cyc ? r_cyc[8*w_idx_nx[1:0] +: 8] : r_x[8*w_idx_nx +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cyc <= '0;
        else if (r_state == IDLE && r_cmd_ready && cmd_valid && w_op == 4'd2)
            r_cyc <= '0;
        else if (!r_core_ld && r_cyc != 32'hFFFF_FFFF)
            r_cyc <= r_cyc + 1'b1;
    end
`else
    assign w_last    = r_idx == IW'(NB - 1);
    assign w_byte_nx = r_x[8*w_idx_nx +: 8];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_rounds    <= '0;
            r_idx       <= '0;
            r_rsp_data  <= '0;
            r_first     <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_core_ld   <= 1'b1;
            r_busy      <= 1'b0;
`ifdef TIMELOCK_SEQ_CYCLE_COUNT_EN
            r_rd_cyc    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_cmd_ready) begin
                        r_cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        case (w_op)
                            4'd0: begin
                                r_x         <= {w_arg, r_x[2*W-1:4]};
                                r_rsp_data  <= {r_x[3:0], 4'h8};
                                r_rsp_valid <= 1'b1;
                                r_state     <= RESP;
                            end
                            4'd1: begin
                                r_rounds    <= {w_arg, r_rounds[RW-1:4]};
                                r_rsp_data  <= {r_rounds[3:0], 4'h9};
                                r_rsp_valid <= 1'b1;
                                r_state     <= RESP;
                            end
                            4'd2: begin
                                if (r_rounds == '0) begin
                                    r_rsp_data  <= 8'h0A;
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= RESP;
                                end else begin
                                    r_state <= CORE_LD;
                                end
                            end
                            4'd3: begin
                                r_idx       <= '0;
                                r_rsp_data  <= r_x[7:0];
                                r_rsp_valid <= 1'b1;
                                r_state     <= READ_OUT;
`ifdef TIMELOCK_SEQ_CYCLE_COUNT_EN
                                r_rd_cyc    <= 1'b0;
`endif
                            end
`ifdef TIMELOCK_SEQ_CYCLE_COUNT_EN
                            4'd4: begin
                                r_idx       <= '0;
                                r_rsp_data  <= r_cyc[7:0];
                                r_rsp_valid <= 1'b1;
                                r_state     <= READ_OUT;
                                r_rd_cyc    <= 1'b1;
                            end
`endif
                            default: begin
                                r_rsp_data  <= 8'hFF;
                                r_rsp_valid <= 1'b1;
                                r_state     <= RESP;
                            end
                        endcase
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                CORE_LD: begin
                    r_core_ld <= 1'b0;
                    r_first   <= 1'b1;
                    r_state   <= CORE_WAIT;
                end
                CORE_WAIT: begin
                    // a done left over from the previous round is masked for one cycle
                    r_first <= 1'b0;
                    if (!r_first && core_dn) begin
                        r_x       <= {core_yc, core_ys};
                        r_rounds  <= r_rounds - 1'b1;
                        r_core_ld <= 1'b1;
                        if (r_rounds == RW'(1)) begin
                            r_rsp_data  <= 8'h0A;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_state <= CORE_LD;
                        end
                    end
                end
                READ_OUT: begin
                    if (rsp_ready) begin
                        if (w_last) begin
                            r_rsp_valid <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_idx      <= w_idx_nx;
                            r_rsp_data <= w_byte_nx;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign core_ld   = r_core_ld;
    assign busy      = r_busy;
    assign core_xs   = r_x[W-1:0];
    assign core_xc   = r_x[2*W-1:W];
endmodule

// File: tb/tb_timelock_sequencer.sv
// tb_timelock_sequencer: directed bench for timelock_sequencer with a fixed-latency core model.
module tb_timelock_sequencer;
    localparam int W  = 184;
    localparam int NB = 2 * W / 8;

    logic         clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0, core_dn;
    logic [7:0]   cmd_data = 8'h00;
    logic         cmd_ready, rsp_valid, core_ld, busy;
    logic [7:0]   rsp_data;
    logic [W-1:0] core_xs, core_xc, core_ys, core_yc;

    int checks = 0, errors = 0;
    int core_cnt, falls = 0, ld_hi = 0, ld_lo = 0;
    logic prev_ld = 1'b1;

    timelock_sequencer #(.W(W), .RW(32)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .core_ld(core_ld),
        .core_xs(core_xs), .core_xc(core_xc), .core_dn(core_dn), .core_ys(core_ys), .core_yc(core_yc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] f(input logic [2*W-1:0] v);
        return {v[2*W-5:0], v[2*W-1:2*W-4]} ^ {NB{8'h5A}};
    endfunction

    assign {core_yc, core_ys} = f({core_xc, core_xs});

    // core model: done pulses for one cycle, 10 cycles after ld falls
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt <= 0;
            core_dn  <= 1'b0;
        end else if (core_ld) begin
            core_cnt <= 0;
            core_dn  <= 1'b0;
        end else begin
            core_cnt <= core_cnt + 1;
            core_dn  <= (core_cnt == 9);
        end
    end

    always @(negedge clk) begin
        if (prev_ld && !core_ld) falls++;
        if (core_ld && busy && !rsp_valid) ld_hi++;
        if (!core_ld) ld_lo++;
        prev_ld = core_ld;
    end

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] arg);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = {arg, op};
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] b);
        int n = 0;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_wait", rsp_valid, 1);
        b = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic cmd_rsp(input logic [3:0] op, input logic [3:0] arg, input string tag, input logic [7:0] exp);
        logic [7:0] b;
        send(op, arg);
        get_rsp(b);
        check(tag, b, exp);
    endtask

    task automatic read_x(input logic [2*W-1:0] exp, input int stall_at, input string tag);
        logic [7:0] b;
        send(4'd3, 4'd0);
        for (int i = 0; i < NB; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    check("stall_data", rsp_data, exp[8*i +: 8]);
                    check("stall_cmd_ready", cmd_ready, 0);
                end
            end
            get_rsp(b);
            check(tag, b, exp[8*i +: 8]);
        end
    endtask

    task automatic set_rounds(input logic [3:0] r);
        logic [31:0] r_m = 32'h0;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] a;
            a = (k == 0) ? r : 4'h0;
            cmd_rsp(4'd1, a, "rounds_ack", {r_m[3:0], 4'h9});
            r_m = {a, r_m[31:4]};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [2*W-1:0] x_m;
        logic [7:0] b;
        int n;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_core_ld", core_ld, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        x_m = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            logic [3:0] nib;
            nib = 4'((i % 15) + 1);
            cmd_rsp(4'd0, nib, "load_ack", {x_m[3:0], 4'h8});
            x_m = {nib, x_m[2*W-1:4]};
        end
        read_x(x_m, -1, "read_load");

        set_rounds(4'd3);
        falls = 0; ld_hi = 0; ld_lo = 0;
        cmd_rsp(4'd2, 4'd0, "run3_rsp", 8'h0A);
        check("run3_ld_falls", falls, 3);
        check("run3_ld_pulses", ld_hi, 3);
        check("run3_ld_low", ld_lo, 33);
        x_m = f(f(f(x_m)));
        read_x(x_m, -1, "read_run3");

        ld_lo = 0;
        send(4'd2, 4'd0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("run0_latency", n <= 2, 1);
        get_rsp(b);
        check("run0_rsp", b, 8'h0A);
        check("run0_ld_low", ld_lo, 0);
        read_x(x_m, 5, "read_run0");

        set_rounds(4'd3);
        falls = 0;
        send(4'd2, 4'd0);
        n = 0;
        while (falls < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("round2_reached", falls, 2);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_core_ld", core_ld, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("abort_no_rsp", n, 0);
        read_x('0, -1, "read_abort");

        cmd_rsp(4'd7, 4'd0, "bad_op", 8'hFF);
        set_rounds(4'd2);
        cmd_rsp(4'd2, 4'd0, "run2_rsp", 8'h0A);
`ifdef TIMELOCK_SEQ_CYCLE_COUNT_EN
        send(4'd4, 4'd0);
        for (int i = 0; i < 4; i++) begin
            get_rsp(b);
            check("cycles_byte", b, (i == 0) ? 8'h16 : 8'h00);
        end
`else
        cmd_rsp(4'd4, 4'd0, "op4_absent", 8'hFF);
`endif
        @(negedge clk);
        check("final_idle", cmd_ready, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
